register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   General-purpose register file of the single-cycle/pipelined MIPS-style datapath.
//   Two combinational read ports feed the ALU operand paths; one clocked write port
//   takes write-back data. Register 0 is hardwired to zero.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of all data ports
//   ADDR_WIDTH  5   register-index width
//   NUM_REGS    32  register count; must equal 2**ADDR_WIDTH
// PORTS
//   Clk                  in   1           clock; writes occur on the rising edge
//   Reset_n              in   1           asynchronous, active-low reset
//   Register_Write       in   1           write enable, sampled on rising Clk
//   Read_Reg_1           in   ADDR_WIDTH  index for read port 1
//   Read_Reg_2           in   ADDR_WIDTH  index for read port 2
//   Write_Reg            in   ADDR_WIDTH  index for the write port
//   Register_Write_Data  in   DATA_WIDTH  write data
//   Read_Data_1          out  DATA_WIDTH  contents of Read_Reg_1
//   Read_Data_2          out  DATA_WIDTH  contents of Read_Reg_2
//   One clock; reset is asynchronous and active-low.
// BEHAVIOUR
//   - Reset: Reset_n low clears all registers to 0 immediately, without waiting for Clk.
//     Both outputs read 0 while reset is held. A write is never performed while Reset_n is low.
//   - Write: on rising Clk with Reset_n high and Register_Write=1, reg[Write_Reg] <= Register_Write_Data.
//     Register_Write=0 leaves every register unchanged.
//   - Register 0: writes with Write_Reg=0 are discarded. Reads of index 0 always return 0.
//   - Read: purely combinational, zero latency. Read_Data_n = (Read_Reg_n==0) ? 0 : reg[Read_Reg_n].
//     Outputs follow any address change within the same cycle.
//   - Read/write same index, same cycle: there is no internal bypass.
//     - Before the edge, the read returns the old value.
//     - After the edge, it returns the new value. Write-before-read forwarding is done
//       outside this block.
//   - Both read ports may address the same register at once. Both then return identical data.
//   - Write data is stored at full width. No sign or zero extension is applied.
//   - X or Z on the read addresses must not corrupt stored state.
//   - Reset asserted mid-operation clears all state. The first write after release takes
//     effect at the first rising Clk with Reset_n high.
// STRUCTURE
//   - Shared package: DATA_WIDTH, ADDR_WIDTH, NUM_REGS, ZERO_REG index (0).
//   - Single module: storage array, write logic with reset clear, two read muxes.
//   - No sub-module; the read port is too small to justify one.
// TESTING
//   1. Hold Reset_n=0 for 2 cycles, read indices 0..31 -> all read 0 on both ports.
//   2. Write with Register_Write=1: 40->r2, 80->r4, 160->r8, 320->r16, 640->r31.
//      Then read r2/r4 and r8/r16 pairwise, r31 on port 2 -> 40, 80, 160, 320, 640 respectively.
//   3. Write 20->r0, then read r0 on both ports -> 0.
//   4. Register_Write=0 with Write_Reg=2, data 0xDEADBEEF; clock 3 edges -> r2 still reads 40.
//   5. Read_Reg_1=5 while writing 0x1234 to r5 -> reads old value (0) before the edge,
//      0x1234 after the edge.
//   6. Pulse Reset_n low between clock edges after scenario 2 -> r31 reads 0 immediately,
//      before the next Clk edge.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared sizing constants for the datapath register file.
// NUM_REGS must stay equal to 2**ADDR_WIDTH so every index maps to a register.
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

endpackage

// File: rtl/register_file.sv
// Two combinational read ports and one clocked write port; register 0 reads as zero.
// There is no write-to-read bypass: forwarding lives in the pipeline, outside this block.
module register_file
    import register_file_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Register_Write,
    input  logic [ADDR_WIDTH-1:0] Read_Reg_1,
    input  logic [ADDR_WIDTH-1:0] Read_Reg_2,
    input  logic [ADDR_WIDTH-1:0] Write_Reg,
    input  logic [DATA_WIDTH-1:0] Register_Write_Data,
    output logic [DATA_WIDTH-1:0] Read_Data_1,
    output logic [DATA_WIDTH-1:0] Read_Data_2
);

    logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];

    // Writes aimed at register 0 are dropped here, so its storage only ever holds zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (Register_Write && (Write_Reg != ZERO_REG)) begin
            regs[Write_Reg] <= Register_Write_Data;
        end
    end

    always_comb begin
        Read_Data_1 = '0;
        Read_Data_2 = '0;
        if (Read_Reg_1 != ZERO_REG) begin
            Read_Data_1 = regs[Read_Reg_1];
        end
        if (Read_Reg_2 != ZERO_REG) begin
            Read_Data_2 = regs[Read_Reg_2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset sweep, table of write/read vectors,
// then hand-written sequences for same-cycle read/write and asynchronous reset.
module tb_register_file;
    import register_file_pkg::*;

    logic                  Clk;
    logic                  Reset_n;
    logic                  Register_Write;
    logic [ADDR_WIDTH-1:0] Read_Reg_1;
    logic [ADDR_WIDTH-1:0] Read_Reg_2;
    logic [ADDR_WIDTH-1:0] Write_Reg;
    logic [DATA_WIDTH-1:0] Register_Write_Data;
    logic [DATA_WIDTH-1:0] Read_Data_1;
    logic [DATA_WIDTH-1:0] Read_Data_2;

    int checks = 0;
    int errors = 0;

    register_file dut (
        .Clk                 (Clk),
        .Reset_n             (Reset_n),
        .Register_Write      (Register_Write),
        .Read_Reg_1          (Read_Reg_1),
        .Read_Reg_2          (Read_Reg_2),
        .Write_Reg           (Write_Reg),
        .Register_Write_Data (Register_Write_Data),
        .Read_Data_1         (Read_Data_1),
        .Read_Data_2         (Read_Data_2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic                  we;
        logic [ADDR_WIDTH-1:0] wa;
        logic [DATA_WIDTH-1:0] wd;
        logic [ADDR_WIDTH-1:0] ra1;
        logic [ADDR_WIDTH-1:0] ra2;
        logic [DATA_WIDTH-1:0] e1;
        logic [DATA_WIDTH-1:0] e2;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                         input logic [DATA_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // Each row: drive at negedge, clock once, compare reads just after the edge.
        vecs[0]  = '{1'b1, 5'd2,  32'd40,        5'd2,  5'd0,  32'd40,        32'd0};
        vecs[1]  = '{1'b1, 5'd4,  32'd80,        5'd4,  5'd2,  32'd80,        32'd40};
        vecs[2]  = '{1'b1, 5'd8,  32'd160,       5'd8,  5'd4,  32'd160,       32'd80};
        vecs[3]  = '{1'b1, 5'd16, 32'd320,       5'd16, 5'd8,  32'd320,       32'd160};
        vecs[4]  = '{1'b1, 5'd31, 32'd640,       5'd2,  5'd31, 32'd40,        32'd640};
        vecs[5]  = '{1'b0, 5'd0,  32'd0,         5'd2,  5'd4,  32'd40,        32'd80};
        vecs[6]  = '{1'b0, 5'd0,  32'd0,         5'd8,  5'd16, 32'd160,       32'd320};
        vecs[7]  = '{1'b1, 5'd0,  32'd20,        5'd0,  5'd0,  32'd0,         32'd0};
        vecs[8]  = '{1'b0, 5'd2,  32'hDEADBEEF,  5'd2,  5'd2,  32'd40,        32'd40};
        vecs[9]  = '{1'b0, 5'd2,  32'hDEADBEEF,  5'd2,  5'd31, 32'd40,        32'd640};
        vecs[10] = '{1'b0, 5'd2,  32'hDEADBEEF,  5'd2,  5'd2,  32'd40,        32'd40};
        vecs[11] = '{1'b1, 5'd10, 32'hFFFFFFFF,  5'd10, 5'd10, 32'hFFFFFFFF,  32'hFFFFFFFF};
        vecs[12] = '{1'b1, 5'd3,  32'h80000001,  5'd3,  5'd1,  32'h80000001,  32'd0};
        vecs[13] = '{1'b1, 5'd1,  32'h00000007,  5'd1,  5'd3,  32'h00000007,  32'h80000001};

        Reset_n             = 1'b0;
        Register_Write      = 1'b0;
        Read_Reg_1          = '0;
        Read_Reg_2          = '0;
        Write_Reg           = '0;
        Register_Write_Data = '0;

        // Reset held two cycles; sweep every index on both ports while still in reset.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        for (int i = 0; i < NUM_REGS; i++) begin
            Read_Reg_1 = ADDR_WIDTH'(i);
            Read_Reg_2 = ADDR_WIDTH'(NUM_REGS - 1 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), Read_Data_1, '0);
            check($sformatf("reset_rd2_r%0d", NUM_REGS - 1 - i), Read_Data_2, '0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge Clk);
            Register_Write      = vecs[i].we;
            Write_Reg           = vecs[i].wa;
            Register_Write_Data = vecs[i].wd;
            Read_Reg_1          = vecs[i].ra1;
            Read_Reg_2          = vecs[i].ra2;
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d_rd1", i), Read_Data_1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), Read_Data_2, vecs[i].e2);
        end

        // Reads follow an address change with no clock edge.
        @(negedge Clk);
        Register_Write = 1'b0;
        Read_Reg_1     = 5'd16;
        Read_Reg_2     = 5'd4;
        #1;
        check("comb_addr_rd1", Read_Data_1, 32'd320);
        check("comb_addr_rd2", Read_Data_2, 32'd80);

        // Same-cycle read and write of r5: old value before the edge, new after.
        @(negedge Clk);
        Read_Reg_1          = 5'd5;
        Read_Reg_2          = 5'd5;
        Write_Reg           = 5'd5;
        Register_Write_Data = 32'h00001234;
        Register_Write      = 1'b1;
        #1;
        check("rw_same_before", Read_Data_1, 32'd0);
        @(posedge Clk);
        #1;
        check("rw_same_after_rd1", Read_Data_1, 32'h00001234);
        check("rw_same_after_rd2", Read_Data_2, 32'h00001234);

        // Asynchronous reset pulse between edges clears r31 without a clock.
        @(negedge Clk);
        Register_Write = 1'b0;
        Read_Reg_1     = 5'd16;
        Read_Reg_2     = 5'd31;
        #1;
        check("pre_reset_r31", Read_Data_2, 32'd640);
        Reset_n = 1'b0;
        #1;
        check("async_reset_r31", Read_Data_2, 32'd0);
        check("async_reset_r16", Read_Data_1, 32'd0);

        // A write requested across an edge while reset is held must not land.
        Write_Reg           = 5'd7;
        Register_Write_Data = 32'hCAFEF00D;
        Register_Write      = 1'b1;
        Read_Reg_1          = 5'd7;
        @(posedge Clk);
        #1;
        check("write_in_reset_r7", Read_Data_1, 32'd0);

        // First edge after release performs the pending write.
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("released_before_edge_r7", Read_Data_1, 32'd0);
        @(posedge Clk);
        #1;
        check("first_write_after_reset_r7", Read_Data_1, 32'hCAFEF00D);
        check("post_reset_r31", Read_Data_2, 32'd0);

        @(negedge Clk);
        Register_Write = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
